// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: operator tags, compute-stage FSM states
// and the default operand widths used by the align/compute/normalise stages.
package fpu_pkg;

    localparam int FPU_MAN_W = 24;
    localparam int FPU_EXP_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } fpu_state_e;

endpackage

// File: rtl/fpu_shift_add_mul.sv
// Radix-2 shift-add mantissa multiplier: one multiplier bit per cycle, LSB
// first, MAN_W iterations after start. done flags the cycle of the last iteration.
module fpu_shift_add_mul #(
    parameter int MAN_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MAN_W-1:0]     multiplicand,
    input  logic [MAN_W-1:0]     multiplier,
    output logic [2*MAN_W-1:0]   accumulator,
    output logic                 done
);

    localparam int CNT_W = (MAN_W > 1) ? $clog2(MAN_W) : 1;

    logic                 r_active;
    logic [CNT_W-1:0]     r_count;
    logic [2*MAN_W-1:0]   r_mcand;
    logic [MAN_W-1:0]     r_mplier;
    logic [2*MAN_W-1:0]   r_acc;

    // Multiplicand shifts left and multiplier shifts right, so bit 0 always
    // selects whether the current partial product is added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_count  <= '0;
            r_mcand  <= {{MAN_W{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_acc    <= '0;
        end else if (r_active) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

    assign done        = r_active && (r_count == CNT_W'(MAN_W - 1));
    assign accumulator = r_acc;

endmodule

// File: rtl/fpu_compute_seq.sv
// FPU compute stage: signed-magnitude ADD/SUB in a single cycle, iterative MUL,
// valid/ready on both sides with a single output register.
module fpu_compute_seq
    import fpu_pkg::*;
#(
    parameter int MAN_W = FPU_MAN_W,
    parameter int EXP_W = FPU_EXP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign_1,
    input  logic                 in_sign_2,
    input  logic [EXP_W-1:0]     in_exponent,
    input  logic [MAN_W-1:0]     in_mantissa_1,
    input  logic [MAN_W-1:0]     in_mantissa_2,
    input  logic [1:0]           in_operator,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sign,
    output logic [EXP_W-1:0]     exponent,
    output logic [2*MAN_W-1:0]   mantissa,
    output logic [1:0]           operator,
    output logic                 busy
);

    fpu_state_e           r_state, w_next_state;
    logic                 w_in_ready, w_slot_free, w_mul_start, w_load_mul, w_load_arith;
    logic                 w_mul_done;
    logic [2*MAN_W-1:0]   w_acc;
    logic                 r_pend_sign;
    logic [EXP_W-1:0]     r_pend_exp;
    logic                 w_s2_eff, w_res_sign;
    logic [MAN_W:0]       w_mag;
    logic                 r_out_valid, r_sign;
    logic [EXP_W-1:0]     r_exponent;
    logic [2*MAN_W-1:0]   r_mantissa;
    logic [1:0]           r_operator;

    fpu_shift_add_mul #(.MAN_W(MAN_W)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (w_mul_start),
        .multiplicand (in_mantissa_1),
        .multiplier   (in_mantissa_2),
        .accumulator  (w_acc),
        .done         (w_mul_done)
    );

    assign w_slot_free = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_mul_start  = 1'b0;
        w_load_mul   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = rst_n && w_slot_free;
                if (in_valid && w_in_ready && in_operator == OP_MUL) begin
                    w_mul_start  = 1'b1;
                    w_next_state = MUL;
                end
            end
            MUL:  if (w_mul_done) w_next_state = DONE;
            DONE: begin
                if (w_slot_free) begin
                    w_load_mul   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_load_arith = in_valid && w_in_ready && (in_operator != OP_MUL);

    // Signed-magnitude add/sub: subtract the smaller magnitude from the larger
    // and take the sign of the larger; an exact zero is always positive.
    always_comb begin
        w_s2_eff   = in_sign_2 ^ (in_operator == OP_SUB);
        w_mag      = '0;
        w_res_sign = 1'b0;
        if (in_sign_1 == w_s2_eff) begin
            w_mag      = {1'b0, in_mantissa_1} + {1'b0, in_mantissa_2};
            w_res_sign = in_sign_1;
        end else if (in_mantissa_1 >= in_mantissa_2) begin
            w_mag      = {1'b0, in_mantissa_1 - in_mantissa_2};
            w_res_sign = in_sign_1;
        end else begin
            w_mag      = {1'b0, in_mantissa_2 - in_mantissa_1};
            w_res_sign = w_s2_eff;
        end
        if (w_mag == '0 || in_operator == OP_RSV || in_operator == OP_MUL) begin
            w_mag      = '0;
            w_res_sign = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_sign <= 1'b0;
            r_pend_exp  <= '0;
        end else if (w_mul_start) begin
            r_pend_sign <= in_sign_1 ^ in_sign_2;
            r_pend_exp  <= in_exponent;
        end
    end

    // A new load takes priority over the drain so accept-and-drain can share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_exponent  <= '0;
            r_mantissa  <= '0;
            r_operator  <= '0;
        end else if (w_load_arith) begin
            r_out_valid <= 1'b1;
            r_sign      <= w_res_sign;
            r_exponent  <= in_exponent;
            r_mantissa  <= {{(MAN_W-1){1'b0}}, w_mag};
            r_operator  <= in_operator;
        end else if (w_load_mul) begin
            r_out_valid <= 1'b1;
            r_sign      <= r_pend_sign;
            r_exponent  <= r_pend_exp;
            r_mantissa  <= w_acc;
            r_operator  <= OP_MUL;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sign      = r_sign;
    assign exponent  = r_exponent;
    assign mantissa  = r_mantissa;
    assign operator  = r_operator;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_compute_seq.sv
// Scoreboard bench for fpu_compute_seq: directed vectors push expected results,
// a negedge monitor pops and compares every output handshake.
module tb_fpu_compute_seq;

    localparam int MAN_W = 24;
    localparam int EXP_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid, in_ready;
    logic                 in_sign_1, in_sign_2;
    logic [EXP_W-1:0]     in_exponent;
    logic [MAN_W-1:0]     in_mantissa_1, in_mantissa_2;
    logic [1:0]           in_operator;
    logic                 out_valid, out_ready;
    logic                 sign;
    logic [EXP_W-1:0]     exponent;
    logic [2*MAN_W-1:0]   mantissa;
    logic [1:0]           operator;
    logic                 busy;

    typedef struct {
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [2*MAN_W-1:0] mant;
        logic [1:0]         op;
    } exp_t;

    typedef struct {
        logic               s1;
        logic [MAN_W-1:0]   m1;
        logic               s2;
        logic [MAN_W-1:0]   m2;
        logic [1:0]         op;
        logic               eSign;
        logic [2*MAN_W-1:0] eMant;
    } vec_t;

    exp_t sbQueue[$];
    exp_t sbItem;
    vec_t vecs[8];
    int   testsRun = 0;
    int   testsFailed = 0;

    fpu_compute_seq #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign_1     (in_sign_1),
        .in_sign_2     (in_sign_2),
        .in_exponent   (in_exponent),
        .in_mantissa_1 (in_mantissa_1),
        .in_mantissa_2 (in_mantissa_2),
        .in_operator   (in_operator),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sign          (sign),
        .exponent      (exponent),
        .mantissa      (mantissa),
        .operator      (operator),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one operand bundle, wait (bounded) for in_ready, and log the expected result.
    task automatic applyStimulus(input logic s1, input logic [MAN_W-1:0] m1,
                                 input logic s2, input logic [MAN_W-1:0] m2,
                                 input logic [EXP_W-1:0] ex, input logic [1:0] op,
                                 input logic expSign, input logic [2*MAN_W-1:0] expMant,
                                 input logic pushExp);
        int waited;
        exp_t e;
        in_sign_1     = s1;
        in_mantissa_1 = m1;
        in_sign_2     = s2;
        in_mantissa_2 = m2;
        in_exponent   = ex;
        in_operator   = op;
        in_valid      = 1'b1;
        waited        = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        if (pushExp) begin
            e.sign = expSign;
            e.exp  = ex;
            e.mant = expMant;
            e.op   = op;
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_output: got mantissa 0x%0h, expected no result", mantissa);
            end else begin
                sbItem = sbQueue.pop_front();
                checkOutput("sb_sign",     64'(sign),     64'(sbItem.sign));
                checkOutput("sb_exponent", 64'(exponent), 64'(sbItem.exp));
                checkOutput("sb_mantissa", 64'(mantissa), 64'(sbItem.mant));
                checkOutput("sb_operator", 64'(operator), 64'(sbItem.op));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lowCount;
        int latency;

        vecs[0] = '{1'b0, 24'h000001, 1'b0, 24'h000002, 2'b00, 1'b0, 48'h000000000003};
        vecs[1] = '{1'b1, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 2'b00, 1'b1, 48'h000001FFFFFE};
        vecs[2] = '{1'b0, 24'h100000, 1'b1, 24'h300000, 2'b00, 1'b1, 48'h000000200000};
        vecs[3] = '{1'b0, 24'h500000, 1'b0, 24'h100000, 2'b01, 1'b0, 48'h000000400000};
        vecs[4] = '{1'b1, 24'h000010, 1'b1, 24'h000010, 2'b01, 1'b0, 48'h000000000000};
        vecs[5] = '{1'b1, 24'h200000, 1'b0, 24'h300000, 2'b01, 1'b1, 48'h000000500000};
        vecs[6] = '{1'b1, 24'h123456, 1'b0, 24'h023456, 2'b00, 1'b1, 48'h000000100000};
        vecs[7] = '{1'b1, 24'hABCDEF, 1'b0, 24'h111111, 2'b11, 1'b0, 48'h000000000000};

        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_sign_1 = 1'b0;
        in_sign_2 = 1'b0;
        in_exponent = '0;
        in_mantissa_1 = '0;
        in_mantissa_2 = '0;
        in_operator = 2'b00;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy",      64'(busy),      64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
        checkOutput("rst_mantissa",  64'(mantissa),  64'd0);
        checkOutput("rst_sign",      64'(sign),      64'd0);
        checkOutput("rst_exponent",  64'(exponent),  64'd0);
        checkOutput("rst_operator",  64'(operator),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset five cycles into a MUL: nothing may ever come out of it.
        applyStimulus(1'b1, 24'h800000, 1'b0, 24'h800000, 8'h20, 2'b10, 1'b1, 48'h400000000000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midmul_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midmul_rst_busy",      64'(busy),      64'd0);
        checkOutput("midmul_rst_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midmul_in_ready_after", 64'(in_ready), 64'd1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("midmul_no_result", 64'(out_valid), 64'd0);

        applyStimulus(1'b0, 24'h800000, 1'b0, 24'h800000, 8'h7F, 2'b00, 1'b0, 48'h000001000000, 1'b1);
        checkOutput("add_latency", 64'(out_valid), 64'd1);
        applyStimulus(1'b0, 24'h800000, 1'b0, 24'h800000, 8'h7F, 2'b01, 1'b0, 48'h000000000000, 1'b1);
        applyStimulus(1'b0, 24'h400000, 1'b0, 24'h800000, 8'h80, 2'b01, 1'b1, 48'h000000400000, 1'b1);

        applyStimulus(1'b1, 24'h800000, 1'b0, 24'h800000, 8'h90, 2'b10, 1'b1, 48'h400000000000, 1'b1);
        lowCount = 0;
        latency  = 0;
        if (!in_ready) lowCount++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                latency = k;
                break;
            end
            if (!in_ready) lowCount++;
        end
        checkOutput("mul_latency",     64'(latency),  64'd25);
        checkOutput("mul_in_ready_lo", 64'(lowCount), 64'd25);
        @(posedge clk);
        #1;

        // Backpressure: a held result must not change while a new ADD waits.
        out_ready = 1'b0;
        applyStimulus(1'b0, 24'h000100, 1'b0, 24'h000200, 8'h33, 2'b00, 1'b0, 48'h000000000300, 1'b1);
        in_sign_1     = 1'b1;
        in_mantissa_1 = 24'h000050;
        in_sign_2     = 1'b1;
        in_mantissa_2 = 24'h000005;
        in_exponent   = 8'h44;
        in_operator   = 2'b00;
        in_valid      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_mant", 64'(mantissa),  64'h300);
            checkOutput("bp_hold_exp",  64'(exponent),  64'h33);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        sbItem.sign = 1'b1;
        sbItem.exp  = 8'h44;
        sbItem.mant = 48'h55;
        sbItem.op   = 2'b00;
        sbQueue.push_back(sbItem);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_new_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_new_mant",  64'(mantissa),  64'h55);
        checkOutput("bp_new_sign",  64'(sign),      64'd1);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            in_sign_1     = vecs[i].s1;
            in_mantissa_1 = vecs[i].m1;
            in_sign_2     = vecs[i].s2;
            in_mantissa_2 = vecs[i].m2;
            in_operator   = vecs[i].op;
            in_exponent   = 8'h10 + 8'(i);
            in_valid      = 1'b1;
            checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
            e.sign = vecs[i].eSign;
            e.exp  = 8'h10 + 8'(i);
            e.mant = vecs[i].eMant;
            e.op   = vecs[i].op;
            sbQueue.push_back(e);
            @(posedge clk);
            #1;
            checkOutput("b2b_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained",     64'(sbQueue.size()), 64'd0);
        checkOutput("final_out_idle", 64'(out_valid),      64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
